// File: rtl/prbs8_checker_pkg.sv
// Shared constants, FSM encoding and the reference-sequence step function for the PRBS8 checker.
// No logic of its own.
package prbs8_checker_pkg;

    localparam logic [7:0] PRBS_SEED = 8'h06;
    localparam int         LOCK_RUN  = 16;
    localparam int         WINDOW    = 16;
    localparam int         LOSS_ERRS = 4;
    localparam int         ERR_W     = 8;

    typedef enum logic {
        ST_HUNT = 1'b0,
        ST_LOCK = 1'b1
    } state_e;

    // One step of the upstream generator: feedback taps on bits 4/2/0, inversions on bits 2/1.
    function automatic logic [7:0] prbs8_next(input logic [7:0] s);
        logic       f;
        logic [7:0] n;
        f    = s[0];
        n[7] = f;
        n[6] = s[7];
        n[5] = s[6];
        n[4] = s[5] ^ f;
        n[3] = s[4];
        n[2] = ~(s[3] ^ f);
        n[1] = ~s[2];
        n[0] = s[1] ^ f;
        return n;
    endfunction

endpackage

// File: rtl/prbs8_checker_if.sv
// Serial bit input and status/debug outputs of the PRBS8 checker.
// master = stream source / observer, slave = checker.
interface prbs8_checker_if;
    import prbs8_checker_pkg::*;

    logic             BIT_IN;
    logic             BIT_VALID;
    logic             CLEAR;
    logic             LOCKED;
    logic             ERR_PULSE;
    logic [ERR_W-1:0] ERR_COUNT;
    logic [7:0]       REF_STATE;

    modport master (
        output BIT_IN, BIT_VALID, CLEAR,
        input  LOCKED, ERR_PULSE, ERR_COUNT, REF_STATE
    );

    modport slave (
        input  BIT_IN, BIT_VALID, CLEAR,
        output LOCKED, ERR_PULSE, ERR_COUNT, REF_STATE
    );

endinterface

// File: rtl/prbs8_ref.sv
// Local copy of the upstream PRBS8 generator; steps once per cycle while EN is high.
// Latency 1; holds its state when EN is low.
module prbs8_ref
    import prbs8_checker_pkg::*;
(
    input  logic       CLK,
    input  logic       RESET,
    input  logic       EN,
    output logic [7:0] STATE
);

    logic [7:0] state_q;
    logic [7:0] state_d;

    always_comb begin
        state_d = state_q;
        if (EN) begin
            state_d = prbs8_next(state_q);
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= PRBS_SEED;
        end else begin
            state_q <= state_d;
        end
    end

    assign STATE = state_q;

endmodule

// File: rtl/prbs8_checker.sv
// PRBS8 checker: hunts for alignment by slipping the reference, then counts bit errors while locked.
// Latency 1 (all outputs registered); BIT_VALID low freezes everything.
module prbs8_checker
    import prbs8_checker_pkg::*;
(
    input  logic           CLK,
    input  logic           RESET,
    prbs8_checker_if.slave bus
);

    state_e           state_q, state_d;
    logic [4:0]       run_q, run_d;
    logic [3:0]       win_q, win_d;
    logic [2:0]       werr_q, werr_d;
    logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
    logic             err_pulse_q, err_pulse_d;

    logic       match;
    logic       ref_en;
    logic [7:0] ref_state;

    assign match = (bus.BIT_IN == ref_state[0]);

    // In HUNT a mismatch holds the reference, slipping it one bit against the stream.
    assign ref_en = bus.BIT_VALID && ((state_q == ST_LOCK) || match);

    prbs8_ref u_ref (
        .CLK   (CLK),
        .RESET (RESET),
        .EN    (ref_en),
        .STATE (ref_state)
    );

    always_comb begin
        logic err_hit;
        state_d     = state_q;
        run_d       = run_q;
        win_d       = win_q;
        werr_d      = werr_q;
        err_cnt_d   = err_cnt_q;
        err_pulse_d = 1'b0;
        err_hit     = 1'b0;

        if (bus.BIT_VALID) begin
            case (state_q)
                ST_HUNT: begin
                    if (match) begin
                        if (run_q == 5'(LOCK_RUN - 1)) begin
                            state_d = ST_LOCK;
                            run_d   = '0;
                            win_d   = '0;
                            werr_d  = '0;
                        end else begin
                            run_d = run_q + 5'd1;
                        end
                    end else begin
                        run_d = '0;
                    end
                end
                ST_LOCK: begin
                    win_d = win_q + 4'd1;
                    if (!match) begin
                        err_hit     = 1'b1;
                        err_pulse_d = 1'b1;
                        if (err_cnt_q != '1) begin
                            err_cnt_d = err_cnt_q + 1'b1;
                        end
                    end
                    // Loss of lock wins over the window wrap on the same bit.
                    if (!match && (werr_q == 3'(LOSS_ERRS - 1))) begin
                        state_d = ST_HUNT;
                        run_d   = '0;
                        win_d   = '0;
                        werr_d  = '0;
                    end else if (win_q == 4'(WINDOW - 1)) begin
                        win_d  = '0;
                        werr_d = '0;
                    end else if (!match) begin
                        werr_d = werr_q + 3'd1;
                    end
                end
                default: state_d = ST_HUNT;
            endcase
        end

        if (bus.CLEAR) begin
            err_cnt_d = err_hit ? ERR_W'(1) : '0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= ST_HUNT;
            run_q       <= '0;
            win_q       <= '0;
            werr_q      <= '0;
            err_cnt_q   <= '0;
            err_pulse_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            run_q       <= run_d;
            win_q       <= win_d;
            werr_q      <= werr_d;
            err_cnt_q   <= err_cnt_d;
            err_pulse_q <= err_pulse_d;
        end
    end

    assign bus.LOCKED    = (state_q == ST_LOCK);
    assign bus.ERR_PULSE = err_pulse_q;
    assign bus.ERR_COUNT = err_cnt_q;
    assign bus.REF_STATE = ref_state;

endmodule

// File: tb/tb_prbs8_checker.sv
// Bench for prbs8_checker: directed stream scenarios, a phase-index reference model compared
// every cycle, and literal expectations at the scenario boundaries.
module tb_prbs8_checker;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    prbs8_checker_if bus ();

    prbs8_checker dut (
        .CLK   (clk),
        .RESET (rst),
        .bus   (bus)
    );

    logic [7:0] gold_st [255];
    int sp = 0;
    int n_checks = 0;
    int n_fail = 0;
    logic cmp_en = 1'b0;

    // Model: reference tracked as a phase index into the golden sequence.
    logic m_lock, m_pulse;
    int   m_run, m_win, m_werr, m_ecnt, m_mi;

    function automatic logic gbit(input int k);
        logic [7:0] s;
        s = gold_st[k % 255];
        return s[0];
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin : mdl
        logic mt, t_lock, t_pulse;
        int   t_run, t_win, t_werr, t_ecnt, t_mi;
        if (rst) begin
            m_lock <= 1'b0; m_pulse <= 1'b0; m_run <= 0; m_win <= 0;
            m_werr <= 0;    m_ecnt <= 0;     m_mi <= 0;
        end else begin
            t_lock = m_lock; t_run = m_run; t_win = m_win; t_werr = m_werr;
            t_ecnt = m_ecnt; t_mi = m_mi;   t_pulse = 1'b0;
            if (bus.BIT_VALID) begin
                mt = (bus.BIT_IN == gbit(t_mi));
                if (t_lock) begin
                    t_mi = (t_mi + 1) % 255;
                    t_win++;
                    if (!mt) begin
                        t_pulse = 1'b1;
                        t_ecnt  = (t_ecnt < 255) ? t_ecnt + 1 : 255;
                        t_werr++;
                    end
                    if (t_werr == 4) begin
                        t_lock = 1'b0; t_run = 0; t_win = 0; t_werr = 0;
                    end else if (t_win == 16) begin
                        t_win = 0; t_werr = 0;
                    end
                end else if (mt) begin
                    t_mi = (t_mi + 1) % 255;
                    t_run++;
                    if (t_run == 16) begin
                        t_lock = 1'b1; t_run = 0; t_win = 0; t_werr = 0;
                    end
                end else begin
                    t_run = 0;
                end
            end
            if (bus.CLEAR) t_ecnt = t_pulse ? 1 : 0;
            m_lock <= t_lock; m_pulse <= t_pulse; m_run <= t_run; m_win <= t_win;
            m_werr <= t_werr; m_ecnt <= t_ecnt;   m_mi <= t_mi;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("cyc_locked",    32'(bus.LOCKED),    32'(m_lock));
            check("cyc_err_pulse", 32'(bus.ERR_PULSE), 32'(m_pulse));
            check("cyc_err_count", 32'(bus.ERR_COUNT), 32'(m_ecnt));
            check("cyc_ref_state", 32'(bus.REF_STATE), 32'(gold_st[m_mi]));
        end
    end

    task automatic send(input logic inv, input logic clr);
        @(negedge clk);
        bus.BIT_VALID = 1'b1;
        bus.BIT_IN    = gbit(sp) ^ inv;
        bus.CLEAR     = clr;
        sp = (sp + 1) % 255;
        @(posedge clk); #1;
    endtask

    task automatic idle();
        @(negedge clk);
        bus.BIT_VALID = 1'b0;
        bus.BIT_IN    = 1'($urandom_range(0, 1));
        bus.CLEAR     = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] s;
        int wins, guard;
        s = 8'h06;
        for (int i = 0; i < 255; i++) begin
            gold_st[i] = s;
            s = ({s[0], s[7:1]} ^ (s[0] ? 8'h15 : 8'h00)) ^ 8'h06;
        end
        check("gold_st1", 32'(gold_st[1]), 32'h05);
        check("gold_st2", 32'(gold_st[2]), 32'h91);
        check("gold_st3", 32'(gold_st[3]), 32'hDB);
        check("gold_st4", 32'(gold_st[4]), 32'hFE);

        // Reset held for two cycles.
        bus.BIT_VALID = 1'b0; bus.BIT_IN = 1'b0; bus.CLEAR = 1'b0; rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_locked", 32'(bus.LOCKED),    32'd0);
        check("rst_count",  32'(bus.ERR_COUNT), 32'd0);
        check("rst_pulse",  32'(bus.ERR_PULSE), 32'd0);
        check("rst_ref",    32'(bus.REF_STATE), 32'h06);
        @(negedge clk);
        rst = 1'b0;
        cmp_en = 1'b1;

        // Aligned stream: lock exactly on the 16th valid bit.
        sp = 0;
        for (int i = 1; i <= 16; i++) begin
            send(1'b0, 1'b0);
            if (i == 1) check("ref_after_bit1", 32'(bus.REF_STATE), 32'h05);
            check("lock_at_16", 32'(bus.LOCKED), 32'(i == 16));
        end
        check("lock_count0", 32'(bus.ERR_COUNT), 32'd0);
        repeat (20) send(1'b0, 1'b0);

        // Single inverted bit while locked, then CLEAR variants.
        send(1'b1, 1'b0);
        check("single_pulse",  32'(bus.ERR_PULSE), 32'd1);
        check("single_count",  32'(bus.ERR_COUNT), 32'd1);
        check("single_locked", 32'(bus.LOCKED),    32'd1);
        send(1'b0, 1'b0);
        check("pulse_one_cycle", 32'(bus.ERR_PULSE), 32'd0);
        send(1'b0, 1'b1);
        check("clear_alone", 32'(bus.ERR_COUNT), 32'd0);
        send(1'b1, 1'b1);
        check("clear_with_err", 32'(bus.ERR_COUNT), 32'd1);
        send(1'b0, 1'b1);
        check("clear_again", 32'(bus.ERR_COUNT), 32'd0);

        // Frozen while BIT_VALID is low.
        repeat (3) idle();
        check("hold_pulse",  32'(bus.ERR_PULSE), 32'd0);
        check("hold_locked", 32'(bus.LOCKED),    32'd1);
        repeat (20) send(1'b0, 1'b0);

        // Four errors in one window drop lock; aligned stream then relocks.
        guard = 0;
        while (m_win != 0 && guard < 32) begin
            send(1'b0, 1'b0);
            guard++;
        end
        for (int p = 0; p < 8; p++) begin
            send(1'(p % 2), 1'b0);
            if (p == 5) check("three_errs_locked", 32'(bus.LOCKED), 32'd1);
        end
        check("loss_unlocked", 32'(bus.LOCKED),    32'd0);
        check("loss_count",    32'(bus.ERR_COUNT), 32'd4);
        for (int i = 0; i < 271 && !bus.LOCKED; i++) send(1'b0, 1'b0);
        check("relock", 32'(bus.LOCKED), 32'd1);

        // Three errors per window, 90 windows, half the cycles invalid: saturate.
        wins = 0;
        guard = 0;
        while (wins < 90 && guard < 4000) begin
            guard++;
            idle();
            if (m_win == 15) wins++;
            send(1'((m_win == 3) || (m_win == 8) || (m_win == 13)), 1'b0);
        end
        check("sat_windows", 32'(wins),          32'd90);
        check("sat_count",   32'(bus.ERR_COUNT), 32'd255);
        check("sat_locked",  32'(bus.LOCKED),    32'd1);

        // Reset wins over a coincident valid mismatch and CLEAR.
        @(negedge clk);
        rst = 1'b1; bus.BIT_VALID = 1'b1; bus.BIT_IN = ~gbit(sp); bus.CLEAR = 1'b1;
        @(posedge clk); #1;
        check("rst2_locked", 32'(bus.LOCKED),    32'd0);
        check("rst2_count",  32'(bus.ERR_COUNT), 32'd0);
        check("rst2_pulse",  32'(bus.ERR_PULSE), 32'd0);
        check("rst2_ref",    32'(bus.REF_STATE), 32'h06);
        @(negedge clk);
        rst = 1'b0; bus.BIT_VALID = 1'b0; bus.CLEAR = 1'b0;

        // Stream 37 bits behind the reference: hunt, no error pulses, then lock.
        sp = 255 - 37;
        for (int i = 0; i < 271 && !bus.LOCKED; i++) begin
            send(1'b0, 1'b0);
            if (!bus.LOCKED) check("hunt_no_pulse", 32'(bus.ERR_PULSE), 32'd0);
        end
        check("offset_lock",  32'(bus.LOCKED),    32'd1);
        check("offset_count", 32'(bus.ERR_COUNT), 32'd0);

        repeat (2) idle();
        cmp_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/prbs8_checker.md
PRBS8_CHECKER -- requirements
Module: prbs8_checker

Interface
REQ-001 SHALL expose: CLK  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL expose: RESET  input  1  reset, synchronous, active-high.
REQ-003 SHALL expose: BIT_IN  input  1  received serial bit from the upstream 8-bit PRBS generator path.
REQ-004 SHALL expose: BIT_VALID  input  1  BIT_IN is meaningful this cycle; low = checker frozen.
REQ-005 SHALL expose: CLEAR  input  1  zero ERR_COUNT, no state change.
REQ-006 SHALL expose: LOCKED  output  1  registered; 1 = reference aligned to stream.
REQ-007 SHALL expose: ERR_PULSE  output  1  registered; one-cycle pulse per counted mismatch.
REQ-008 SHALL expose: ERR_COUNT  output  8  registered saturating count of mismatches while locked.
REQ-009 SHALL expose: REF_STATE  output  8  current reference generator state, for debug.

Function
REQ-010 Reference generator SHALL reproduce the upstream sequence; with s = REF_STATE and f = s[0], next state SHALL be n7=f, n6=s7, n5=s6, n4=s5^f, n3=s4, n2=~(s3^f), n1=~s2, n0=s1^f.
REQ-011 Reference bit SHALL be REF_STATE[0]; compare is combinational against BIT_IN in the BIT_VALID cycle; all results are visible after the following edge (latency 1).
REQ-012 With BIT_VALID=0, all state, counters and the reference SHALL hold, and ERR_PULSE SHALL be 0 next cycle.
REQ-013 FSM SHALL have two states, HUNT and LOCK; the state is reflected on LOCKED.
REQ-014 In HUNT, on a valid match: advance reference; increment run counter (5-bit).
REQ-015 In HUNT, on a valid mismatch: hold reference (one-bit slip); clear run counter; no ERR_PULSE; ERR_COUNT unchanged.
REQ-016 HUNT->LOCK SHALL occur on the edge ending the 16th consecutive valid match; clear window counters.
REQ-017 In LOCK, every valid bit SHALL advance the reference regardless of match.
REQ-018 In LOCK, on a valid mismatch: ERR_PULSE=1; ERR_COUNT+1 saturating at 255; window error counter +1.
REQ-019 Window counter (4-bit) SHALL count valid bits in LOCK; on the edge ending the 16th bit it wraps to 0 and clears the window error counter.
REQ-020 LOCK->HUNT SHALL occur when the window error counter would reach 4; the loss takes priority over the window wrap in the same cycle; run counter cleared; reference not reset.
REQ-021 CLEAR coincident with a counted mismatch SHALL yield ERR_COUNT=1; CLEAR alone yields 0.

Reset
REQ-022 On RESET=1 at an edge: state HUNT, LOCKED=0, ERR_PULSE=0, ERR_COUNT=0, run/window counters 0, REF_STATE=0x06.
REQ-023 RESET SHALL override BIT_VALID, CLEAR and any in-flight lock or error event in the same cycle.

Structure
REQ-024 Shared package SHALL hold: seed 0x06, LOCK_RUN=16, WINDOW=16, LOSS_ERRS=4, ERR_COUNT width 8, FSM state encoding.
REQ-025 Reference generator SHALL be one sub-module, prbs8_ref (ports CLK, RESET, EN, STATE[7:0]), implementing REQ-010 with synchronous reset to seed.

Verification
REQ-026 Reset: hold RESET 2 cycles -> LOCKED=0, ERR_COUNT=0x00, ERR_PULSE=0, REF_STATE=0x06.
REQ-027 Aligned stream from a golden model seeded 0x06, BIT_VALID=1 continuously -> LOCKED=1 after the edge ending valid bit 16, ERR_COUNT=0.
REQ-028 Golden stream offset by 37 bits -> LOCKED rises within 255+16 valid bits; no ERR_PULSE during HUNT.
REQ-029 Locked, invert one bit -> ERR_PULSE single cycle, ERR_COUNT=1, LOCKED stays 1; CLEAR -> 0.
REQ-030 Locked, invert 4 bits within one 16-bit window -> LOCKED=0 after the 4th; ERR_COUNT=4; relocks within 255+16 bits.
REQ-031 Locked, 3 inverted bits per window for 90 windows, BIT_VALID toggled 50% -> ERR_COUNT saturates at 255, LOCKED stays 1.
